// File: rtl/sdram_device_responder.sv
// sdram_device_responder: SDRAM device model with open-row tracking, CAS-latency read pipeline and protocol checking
module sdram_device_responder #(
  parameter int CAS_LAT  = 3,
  parameter int ROW_BITS = 2,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] sdram_dqi,
  output logic [31:0] sdram_dqo,
  output logic        rd_valid,
  output logic        proto_err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt,
  output logic [12:0] mode_reg
);
  localparam int AW = ROW_BITS + 10;
  localparam logic [3:0] RCD = 4'(T_RCD);
  localparam logic [3:0] RP = 4'(T_RP);

  typedef enum logic {CLOSED, OPEN} bank_e;

  bank_e         bank_q [4];
  logic [12:0]   row_q [4];
  logic [3:0]    age_q [4];
  logic [32:0]   pipe_q [CAS_LAT];
  logic [31:0]   mem_q [2**AW];
  logic [3:0]    cmd;
  logic          is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
  logic          hit, any_open;
  logic [3:0]    age;
  logic [2:0]    err_d;
  logic [AW-1:0] idx;
  logic [32:0]   push_d;

  assign cmd      = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
  assign is_act   = sdram_cle && cmd == 4'b0011;
  assign is_rd    = sdram_cle && cmd == 4'b0101;
  assign is_wr    = sdram_cle && cmd == 4'b0100;
  assign is_pre   = sdram_cle && cmd == 4'b0010;
  assign is_ref   = sdram_cle && cmd == 4'b0001;
  assign is_lmr   = sdram_cle && cmd == 4'b0000;
  assign hit      = bank_q[sdram_ba] == OPEN;
  assign age      = age_q[sdram_ba];
  assign any_open = bank_q[0] == OPEN || bank_q[1] == OPEN || bank_q[2] == OPEN || bank_q[3] == OPEN;
  // Storage aliases on the low row bits; row-hit tracking keeps the full row.
  assign idx      = {row_q[sdram_ba][ROW_BITS-1:0], sdram_ba, sdram_a[9:2]};
  // A read from a closed bank still occupies a pipeline slot, returning zero data.
  assign push_d   = {is_rd, (is_rd && hit) ? mem_q[idx] : 32'h0};
  assign err_d    = (is_rd || is_wr) ? (!hit ? 3'd1 : age < RCD ? 3'd3 : 3'd0) :
                    is_act ? (hit ? 3'd2 : age < RP ? 3'd4 : 3'd0) :
                    (is_ref && any_open) ? 3'd5 : 3'd0;

  // Bank state, open rows, saturating age counters and sticky status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= CLOSED;
        row_q[b]  <= '0;
        age_q[b]  <= 4'hF;
      end
      proto_err   <= 1'b0;
      err_code    <= '0;
      refresh_cnt <= '0;
      mode_reg    <= '0;
    end else if (sdram_cle) begin
      for (int b = 0; b < 4; b++) begin
        if ((is_act || is_pre) && (sdram_ba == 2'(b) || (is_pre && sdram_a[10])))
          age_q[b] <= 4'h0;
        else if (age_q[b] != 4'hF)
          age_q[b] <= age_q[b] + 4'h1;
        if (is_act && sdram_ba == 2'(b)) begin
          bank_q[b] <= OPEN;
          row_q[b]  <= sdram_a;
        end else if (is_pre && (sdram_ba == 2'(b) || sdram_a[10]))
          bank_q[b] <= CLOSED;
      end
      if (err_d != 3'd0 && !proto_err) begin
        proto_err <= 1'b1;
        err_code  <= err_d;
      end
      if (is_ref)
        refresh_cnt <= refresh_cnt + 16'd1;
      if (is_lmr)
        mode_reg <= sdram_a;
    end
  end

  // Read pipeline; the output register is the final stage so data lands CAS_LAT edges after the READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CAS_LAT; i++)
        pipe_q[i] <= '0;
      rd_valid  <= 1'b0;
      sdram_dqo <= '0;
    end else if (sdram_cle) begin
      pipe_q[0] <= push_d;
      for (int i = 1; i < CAS_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      {rd_valid, sdram_dqo} <= pipe_q[CAS_LAT-1];
    end
  end

  // Word storage; contents survive reset, masked or closed-bank writes are dropped
  always_ff @(posedge clk) begin
    if (rst && is_wr && hit && !sdram_dqm)
      mem_q[idx] <= sdram_dqi;
  end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: table-driven cycle vectors plus hand-written latency and async-reset sequences
module tb_sdram_device_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, DES = 4'b1000;

  typedef struct {
    logic        r, c;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        m;
    logic [31:0] di;
    logic        v;
    logic [31:0] dq;
    logic        pe;
    logic [2:0]  ec;
    logic [15:0] rc;
    logic [12:0] mr;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0, cle = 1'b1;
  logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1, dqm = 1'b0;
  logic [1:0]  ba = '0;
  logic [12:0] a = '0;
  logic [31:0] dqi = '0;
  logic [31:0] dqo;
  logic        rd_valid, proto_err;
  logic [2:0]  err_code;
  logic [15:0] refresh_cnt;
  logic [12:0] mode_reg;

  int n_run = 0, n_fail = 0;
  vec_t tv[$];
  logic        e_pe;
  logic [2:0]  e_ec;
  logic [15:0] e_rc;
  logic [12:0] e_mr;

  sdram_device_responder dut (
    .clk(clk), .rst(rst), .sdram_cle(cle), .sdram_cs(cs), .sdram_ras(ras),
    .sdram_cas(cas), .sdram_we(we), .sdram_dqm(dqm), .sdram_ba(ba), .sdram_a(a),
    .sdram_dqi(dqi), .sdram_dqo(dqo), .rd_valid(rd_valid), .proto_err(proto_err),
    .err_code(err_code), .refresh_cnt(refresh_cnt), .mode_reg(mode_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, got, exp);
    end
  endtask

  task automatic cy(input logic r, input logic c, input logic [3:0] cmd, input logic [1:0] b,
                    input logic [12:0] ad, input logic m, input logic [31:0] di,
                    input logic v, input logic [31:0] dq);
    vec_t t;
    t.r = r; t.c = c; t.cmd = cmd; t.ba = b; t.a = ad; t.m = m; t.di = di;
    t.v = v; t.dq = dq; t.pe = e_pe; t.ec = e_ec; t.rc = e_rc; t.mr = e_mr;
    tv.push_back(t);
  endtask

  task automatic op(input logic [3:0] cmd, input logic [1:0] b, input logic [12:0] ad,
                    input logic [31:0] di, input logic m);
    cy(1'b1, 1'b1, cmd, b, ad, m, di, 1'b0, 32'h0);
  endtask

  task automatic nop(input logic v, input logic [31:0] dq);
    cy(1'b1, 1'b1, NOP, 2'd0, 13'd0, 1'b0, 32'h0, v, dq);
  endtask

  task automatic rs();
    e_pe = 1'b0; e_ec = 3'd0; e_rc = 16'd0; e_mr = 13'd0;
    cy(1'b0, 1'b1, NOP, 2'd0, 13'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic drv(input logic r, input logic c, input logic [3:0] cmd, input logic [1:0] b,
                     input logic [12:0] ad, input logic m, input logic [31:0] di);
    rst = r; cle = c; {cs, ras, cas, we} = cmd; ba = b; a = ad; dqm = m; dqi = di;
  endtask

  initial begin
    int lat, pulses;
    rs();
    op(ACT, 0, 13'd5, 0, 0);
    repeat (4) nop(0, 0);
    op(WR, 0, 13'd32, 32'hDEADBEEF, 0);
    op(RD, 0, 13'd32, 0, 0);
    nop(0, 0); nop(0, 0); nop(1, 32'hDEADBEEF);
    for (int c = 0; c < 4; c++) op(WR, 0, 13'(c * 4), 32'h10 + c, 0);
    op(RD, 0, 13'd0, 0, 0); op(RD, 0, 13'd4, 0, 0); op(RD, 0, 13'd8, 0, 0);
    cy(1, 1, RD, 0, 13'd12, 0, 0, 1, 32'h10);
    nop(1, 32'h11); nop(1, 32'h12); nop(1, 32'h13); nop(0, 0);
    op(WR, 0, 13'd16, 32'hAAAA, 0); op(WR, 0, 13'd16, 32'h1234, 1); op(RD, 0, 13'd16, 0, 0);
    nop(0, 0); nop(0, 0); nop(1, 32'hAAAA);
    e_mr = 13'h0032; op(LMR, 0, 13'h0032, 0, 0);
    op(RD, 0, 13'd32, 0, 0); nop(0, 0);
    cy(1, 0, RD, 0, 13'd0, 0, 0, 0, 32'h0); cy(1, 0, RD, 0, 13'd0, 0, 0, 0, 32'h0);
    nop(0, 0); nop(1, 32'hDEADBEEF);
    cy(1, 0, REF, 0, 13'd0, 0, 0, 1, 32'hDEADBEEF);
    nop(0, 0);
    op(PRE, 0, 13'h400, 0, 0);
    e_rc = 16'd1; op(REF, 0, 0, 0, 0);
    e_rc = 16'd2; op(REF, 0, 0, 0, 0);
    e_rc = 16'd3; op(REF, 0, 0, 0, 0);
    op(DES, 0, 0, 0, 0);
    rs();
    op(ACT, 0, 13'd5, 0, 0); repeat (4) nop(0, 0);
    e_pe = 1; e_ec = 3'd1; op(RD, 2, 13'd0, 0, 0); nop(0, 0);
    op(ACT, 0, 13'd5, 0, 0); nop(1, 32'h0); nop(0, 0);
    rs();
    op(ACT, 0, 13'd5, 0, 0);
    e_pe = 1; e_ec = 3'd3; op(RD, 0, 13'd32, 0, 0);
    nop(0, 0); nop(0, 0); nop(1, 32'hDEADBEEF);
    rs();
    op(PRE, 1, 13'd0, 0, 0);
    e_pe = 1; e_ec = 3'd4; op(ACT, 1, 13'd0, 0, 0);
    rs();
    op(PRE, 1, 13'd0, 0, 0); repeat (3) nop(0, 0);
    op(ACT, 1, 13'd0, 0, 0); repeat (3) nop(0, 0);
    op(WR, 1, 13'd0, 32'h55, 0); op(RD, 1, 13'd0, 0, 0);
    nop(0, 0); nop(0, 0); nop(1, 32'h55);
    e_pe = 1; e_ec = 3'd5; e_rc = 16'd1; op(REF, 0, 0, 0, 0);
    op(ACT, 1, 13'd7, 0, 0);
    rs();
    op(ACT, 0, 13'd5, 0, 0); repeat (4) nop(0, 0);
    op(RD, 0, 13'd32, 0, 0); nop(0, 0);
    rs(); nop(0, 0); nop(0, 0); nop(0, 0);
    op(PRE, 0, 13'd0, 0, 0); repeat (3) nop(0, 0);
    op(ACT, 0, 13'h1005, 0, 0); repeat (3) nop(0, 0);
    op(RD, 0, 13'd32, 0, 0); nop(0, 0); nop(0, 0); nop(1, 32'hDEADBEEF);

    for (int i = 0; i < tv.size(); i++) begin
      vec_t t;
      t = tv[i];
      @(negedge clk);
      drv(t.r, t.c, t.cmd, t.ba, t.a, t.m, t.di);
      @(posedge clk);
      #1;
      chk("rd_valid", i, 32'(rd_valid), 32'(t.v));
      chk("sdram_dqo", i, dqo, t.dq);
      chk("proto_err", i, 32'(proto_err), 32'(t.pe));
      chk("err_code", i, 32'(err_code), 32'(t.ec));
      chk("refresh_cnt", i, 32'(refresh_cnt), 32'(t.rc));
      chk("mode_reg", i, 32'(mode_reg), 32'(t.mr));
    end

    @(negedge clk); drv(1, 1, RD, 0, 13'd32, 0, 0);
    @(negedge clk); drv(1, 1, NOP, 0, 13'd0, 0, 0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (rd_valid) lat = i;
    end
    chk("read_latency", -1, 32'(lat), 32'd3);
    chk("latency_data", -1, dqo, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("valid_one_cycle", -1, 32'(rd_valid), 32'd0);

    @(negedge clk); drv(1, 1, RD, 0, 13'd32, 0, 0);
    @(negedge clk); drv(1, 1, NOP, 0, 13'd0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", -2, 32'(rd_valid), 32'd0);
    chk("async_rst_dqo", -2, dqo, 32'h0);
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rd_valid) pulses++;
    end
    chk("rst_discard_pulses", -2, 32'(pulses), 32'd0);
    chk("rst_proto_err", -2, 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
